// File: rtl/mdu_iterative_pkg.sv
// ---------------------------------------------------------------------------
// mdu_iterative_pkg
//   Shared definitions for the decoder, the single-cycle ALU and the
//   multiply/divide unit.
//   - XLEN, CTL_W       : datapath and alu_ctl widths
//   - ALU_MUL..ALU_REMU : RV32M alu_ctl codes consumed by the MDU
//   - mdu_state_t       : MDU FSM state encoding
//   - is_mdu_op / is_div_op / is_mul_op : alu_ctl classification helpers
// ---------------------------------------------------------------------------
package mdu_iterative_pkg;

    localparam int XLEN  = 32;
    localparam int CTL_W = 5;

    localparam logic [CTL_W-1:0] ALU_MUL    = 5'b00010;
    localparam logic [CTL_W-1:0] ALU_MULH   = 5'b00011;
    localparam logic [CTL_W-1:0] ALU_MULHSU = 5'b00100;
    localparam logic [CTL_W-1:0] ALU_MULHU  = 5'b00101;
    localparam logic [CTL_W-1:0] ALU_DIV    = 5'b00110;
    localparam logic [CTL_W-1:0] ALU_DIVU   = 5'b00111;
    localparam logic [CTL_W-1:0] ALU_REM    = 5'b01000;
    localparam logic [CTL_W-1:0] ALU_REMU   = 5'b01001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_mdu_op(input logic [CTL_W-1:0] ctl);
        return (ctl >= ALU_MUL) && (ctl <= ALU_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [CTL_W-1:0] ctl);
        return (ctl >= ALU_MUL) && (ctl <= ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [CTL_W-1:0] ctl);
        return (ctl >= ALU_DIV) && (ctl <= ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// ---------------------------------------------------------------------------
// mdu_iterative_if
//   Request/response bundle between the execute stage and the MDU.
//   Handshake: a request is taken on a clk edge where start=1, flush=0,
//   busy=0 and alu_ctl is an RV32M code; there is no ready/backpressure,
//   a request seen while busy is simply dropped. done pulses for one cycle
//   when result holds the answer; result then holds until the next
//   completed operation.
//   master (pipeline): drives start, alu_ctl, op_a, op_b, flush
//   slave  (MDU)     : drives busy, done, result, state (debug view of FSM)
// ---------------------------------------------------------------------------
interface mdu_iterative_if;
    import mdu_iterative_pkg::*;

    logic             start;
    logic [CTL_W-1:0] alu_ctl;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    mdu_state_t       state;

    modport master (
        output start, alu_ctl, op_a, op_b, flush,
        input  busy, done, result, state
    );

    modport slave (
        input  start, alu_ctl, op_a, op_b, flush,
        output busy, done, result, state
    );

endinterface

// File: rtl/mdu_iterative_div_core.sv
// ---------------------------------------------------------------------------
// mdu_iterative_div_core
//   Unsigned 32-bit restoring divider datapath, one quotient bit per step.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : capture dividend/divisor, clear remainder and counter
//     step       : perform one restoring step
//     dividend   : unsigned dividend (magnitude)
//     divisor    : unsigned divisor (magnitude, non-zero)
//     quot_step  : quotient as it will be after the current step
//     rem_step   : remainder as it will be after the current step
//     last       : current step is the 32nd (counter==31)
//   The *_step outputs are the combinational results of this cycle's step
//   so the owner can register the final answer on the same edge that the
//   last step completes.
// ---------------------------------------------------------------------------
module mdu_iterative_div_core
    import mdu_iterative_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot_step,
    output logic [XLEN-1:0] rem_step,
    output logic            last
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dvsr_q;
    logic [4:0]      count_q;

    // rem < divisor always, so the shifted partial remainder fits in 33 bits
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        trial   = shifted - {1'b0, dvsr_q};
        if (!trial[XLEN]) begin
            rem_step  = trial[XLEN-1:0];
            quot_step = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step  = shifted[XLEN-1:0];
            quot_step = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    assign last = (count_q == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            rem_q   <= '0;
            quot_q  <= dividend;
            dvsr_q  <= divisor;
            count_q <= '0;
        end else if (step) begin
            rem_q   <= rem_step;
            quot_q  <= quot_step;
            count_q <= count_q + 5'd1;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// ---------------------------------------------------------------------------
// mdu_iterative
//   RV32M multiply/divide unit beside the single-cycle ALU.
//   Multiplies finish in one cycle; divides/remainders run a 32-step
//   restoring divider. RISC-V divide-by-zero and signed-overflow results
//   are produced directly in one cycle.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset
//     bus  : mdu_iterative_if.slave (start/alu_ctl/op_a/op_b/flush in,
//            busy/done/result/state out)
// ---------------------------------------------------------------------------
module mdu_iterative
    import mdu_iterative_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mdu_iterative_if.slave bus
);

    mdu_state_t      state;
    mdu_state_t      state_nxt;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_nxt;
    logic            result_we;
    logic            core_load;

    // Flags of the divide in flight
    logic            rem_sel_q;
    logic            neg_q_q;
    logic            neg_r_q;

    // ---------------- request decode ----------------
    logic            is_signed_div;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;

    assign is_signed_div = (bus.alu_ctl == ALU_DIV) || (bus.alu_ctl == ALU_REM);
    assign is_rem        = (bus.alu_ctl == ALU_REM) || (bus.alu_ctl == ALU_REMU);
    assign a_neg         = is_signed_div && bus.op_a[XLEN-1];
    assign b_neg         = is_signed_div && bus.op_b[XLEN-1];
    assign mag_a         = a_neg ? -bus.op_a : bus.op_a;
    assign mag_b         = b_neg ? -bus.op_b : bus.op_b;
    assign div_zero      = (bus.op_b == '0);
    assign div_ovf       = is_signed_div && (bus.op_a == 32'h8000_0000) &&
                           (bus.op_b == 32'hFFFF_FFFF);

    // ---------------- multiplier ----------------
    // The low 64 bits of the 66-bit product of 33-bit extended operands
    // equal the 64-bit product of the same operands extended to 64 bits,
    // which is all MUL/MULH* ever return.
    logic            sext_a;
    logic            sext_b;
    logic [63:0]     mul_a;
    logic [63:0]     mul_b;
    logic [63:0]     product;
    logic [XLEN-1:0] mul_res;

    assign sext_a  = ((bus.alu_ctl == ALU_MULH) || (bus.alu_ctl == ALU_MULHSU)) &&
                     bus.op_a[XLEN-1];
    assign sext_b  = (bus.alu_ctl == ALU_MULH) && bus.op_b[XLEN-1];
    assign mul_a   = {{32{sext_a}}, bus.op_a};
    assign mul_b   = {{32{sext_b}}, bus.op_b};
    assign product = mul_a * mul_b;
    assign mul_res = (bus.alu_ctl == ALU_MUL) ? product[31:0] : product[63:32];

    // ---------------- divider datapath ----------------
    logic [XLEN-1:0] quot_step;
    logic [XLEN-1:0] rem_step;
    logic            core_last;

    mdu_iterative_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (state == ST_DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quot_step (quot_step),
        .rem_step  (rem_step),
        .last      (core_last)
    );

    // ---------------- FSM: next state / result ----------------
    always_comb begin
        state_nxt  = state;
        result_nxt = result_q;
        result_we  = 1'b0;
        core_load  = 1'b0;
        if (bus.flush) begin
            // Kill wins over everything; an in-flight divide is discarded.
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state_nxt = ST_IDLE;
                    if (bus.start && is_mdu_op(bus.alu_ctl)) begin
                        if (is_mul_op(bus.alu_ctl)) begin
                            state_nxt  = ST_DONE;
                            result_nxt = mul_res;
                            result_we  = 1'b1;
                        end else if (div_zero) begin
                            state_nxt  = ST_DONE;
                            result_nxt = is_rem ? bus.op_a : '1;
                            result_we  = 1'b1;
                        end else if (div_ovf) begin
                            state_nxt  = ST_DONE;
                            result_nxt = is_rem ? '0 : 32'h8000_0000;
                            result_we  = 1'b1;
                        end else begin
                            state_nxt = ST_DIV;
                            core_load = 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (core_last) begin
                        state_nxt = ST_DONE;
                        result_we = 1'b1;
                        if (rem_sel_q)
                            result_nxt = neg_r_q ? -rem_step : rem_step;
                        else
                            result_nxt = neg_q_q ? -quot_step : quot_step;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (result_we)
                result_q <= result_nxt;
            if (core_load) begin
                rem_sel_q <= is_rem;
                neg_q_q   <= a_neg ^ b_neg;
                neg_r_q   <= a_neg;
            end
        end
    end

    assign bus.busy   = (state == ST_DIV);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
    assign bus.state  = state;

endmodule

// File: tb/tb_mdu_iterative.sv
// ---------------------------------------------------------------------------
// tb_mdu_iterative
//   Directed vectors for mdu_iterative. Each issued operation pushes its
//   expected result into exp_q; a monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_mdu_iterative;
    import mdu_iterative_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mdu_iterative_if bus();

    mdu_iterative dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_result = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'b0, bus.done}, 32'h0);
                end else begin
                    check("result", bus.result, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a posedge; returns #1 after a later posedge.
    task automatic do_op(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int exp_busy);
        int lat;
        int busy_n;
        exp_q.push_back(exp);
        bus.start   = 1'b1;
        bus.alu_ctl = ctl;
        bus.op_a    = a;
        bus.op_b    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.done) break;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_n), 32'(exp_busy));
        repeat (3) @(negedge clk);
        check("result_held", bus.result, exp);
        last_result = exp;
        @(posedge clk);
        #1;
    endtask

    task automatic watch_no_done(input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("quiet", {31'b0, seen}, 32'h0);
    endtask

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          busy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1, 0};
        vecs[1]  = '{ALU_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 1, 0};
        vecs[2]  = '{ALU_MULHU,  32'h80000000,   32'h80000000, 32'h40000000, 1, 0};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0};
        vecs[4]  = '{ALU_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33, 32};
        vecs[5]  = '{ALU_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33, 32};
        vecs[6]  = '{ALU_DIVU,   32'd100,        32'd7,        32'd14,       33, 32};
        vecs[7]  = '{ALU_REMU,   32'd100,        32'd7,        32'd2,        33, 32};
        vecs[8]  = '{ALU_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33, 32};
        vecs[9]  = '{ALU_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33, 32};
        vecs[10] = '{ALU_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1, 0};
        vecs[11] = '{ALU_REMU,   32'd5,          32'd0,        32'd5,        1, 0};
        vecs[12] = '{ALU_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 0};
        vecs[13] = '{ALU_REM,    32'h80000000,   32'hFFFFFFFF, 32'h0,        1, 0};
        vecs[14] = '{ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0};
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.start   = 1'b0;
        bus.alu_ctl = 5'd0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.flush   = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   {31'b0, bus.busy}, 32'h0);
        check("reset_done",   {31'b0, bus.done}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        check("reset_state",  {30'b0, bus.state}, {30'b0, ST_IDLE});
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++)
            do_op(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].busy);

        // Divide killed by flush; an intervening MUL start is ignored.
        bus.start = 1'b1; bus.alu_ctl = ALU_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.alu_ctl = ALU_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy",   {31'b0, bus.busy}, 32'h0);
        check("flush_done",   {31'b0, bus.done}, 32'h0);
        check("flush_result", bus.result, last_result);
        watch_no_done(40);
        @(posedge clk);
        #1;
        do_op(ALU_MUL, 32'd3, 32'd4, 32'd12, 1, 0);

        // Non-MDU code is ignored.
        bus.start = 1'b1; bus.alu_ctl = 5'b00000; bus.op_a = 32'd3; bus.op_b = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        watch_no_done(4);
        check("ignored_result", bus.result, last_result);
        @(posedge clk);
        #1;

        // Reset in the middle of a divide.
        bus.start = 1'b1; bus.alu_ctl = ALU_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",   {31'b0, bus.busy}, 32'h0);
        check("midrst_done",   {31'b0, bus.done}, 32'h0);
        check("midrst_result", bus.result, 32'h0);
        watch_no_done(40);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the sequence wedges.
    initial begin
        #200000;
        $display("FAIL timeout: sequence did not complete, got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
